// File: rtl/finv_arbiter_if.sv
// Requester-side bundle of finv_arbiter: operand issue handshake and result writeback.
// Single-cycle pulses on res_*; no backpressure on results.
// master = requester cluster, slave = arbiter.
interface finv_arbiter_if #(
  parameter int NREQ = 2,
  parameter int TAGW = 5
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*32-1:0]   req_x;
  logic [NREQ*TAGW-1:0] req_tag;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      res_valid;
  logic [31:0]          res_y;
  logic [TAGW-1:0]      res_tag;

  modport master (
    output req_valid, req_x, req_tag,
    input  req_ready, res_valid, res_y, res_tag
  );

  modport slave (
    input  req_valid, req_x, req_tag,
    output req_ready, res_valid, res_y, res_tag
  );
endinterface

// File: rtl/finv_arbiter.sv
// Round-robin sharing of one fixed-latency finv unit; tags ride a shadow pipe (FINV_ARB_PERF_EN adds perf counters).
// Latency: result pulse LAT+1 cycles after the transfer cycle; one issue per cycle total.
// Backpressure: req_ready only toward requesters; results are pulses that must be accepted.
module finv_arbiter #(
  parameter int NREQ = 2,
  parameter int LAT  = 4,
  parameter int TAGW = 5
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  finv_arbiter_if.slave        io,
  output logic [31:0]          finv_x,
  input  logic [31:0]          finv_y,
  output logic                 busy
`ifdef FINV_ARB_PERF_EN
  ,
  input  logic                 perf_clr,
  output logic [31:0]          perf_issue,
  output logic [31:0]          perf_conflict
`endif
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]             ptr;
  logic [IW:0]               cand;
  logic                      found;
  logic                      gnt_any;
  logic [IW-1:0]             gnt_id;
  logic [31:0]               gnt_x;
  logic [TAGW-1:0]           gnt_tag;
  logic [LAT-1:0]            sv;
  logic [LAT-1:0][IW-1:0]    sid;
  logic [LAT-1:0][TAGW-1:0]  stag;
  logic [NREQ-1:0]           out_oh;

  // Search ptr, ptr+1, ... with explicit wrap so non-power-of-two NREQ works.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (!found && io.req_valid[cand[IW-1:0]]) begin
        found  = 1'b1;
        gnt_id = cand[IW-1:0];
      end
    end
    gnt_any = found & ~flush & rstn;
  end

  always_comb begin
    gnt_x        = '0;
    gnt_tag      = '0;
    io.req_ready = '0;
    out_oh       = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == IW'(i)) begin
        gnt_x   = io.req_x[i*32 +: 32];
        gnt_tag = io.req_tag[i*TAGW +: TAGW];
      end
      io.req_ready[i] = gnt_any && (gnt_id == IW'(i));
      out_oh[i]       = (sid[LAT-1] == IW'(i));
    end
  end

  assign finv_x = gnt_any ? gnt_x : 32'h0;
  assign busy   = (|sv) | (|io.res_valid);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (gnt_id == IW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Shadow pipe mirrors finv; flush kills every valid bit on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sv   <= '0;
      sid  <= '0;
      stag <= '0;
    end else begin
      sv[0]   <= gnt_any & ~flush;
      sid[0]  <= gnt_id;
      stag[0] <= gnt_tag;
      for (int s = 1; s < LAT; s++) begin
        sv[s]   <= sv[s-1] & ~flush;
        sid[s]  <= sid[s-1];
        stag[s] <= stag[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      io.res_valid <= '0;
      io.res_y     <= '0;
      io.res_tag   <= '0;
    end else if (sv[LAT-1] && !flush) begin
      io.res_valid <= out_oh;
      io.res_y     <= finv_y;
      io.res_tag   <= stag[LAT-1];
    end else begin
      io.res_valid <= '0;
      io.res_y     <= '0;
      io.res_tag   <= '0;
    end
  end

`ifdef FINV_ARB_PERF_EN
  logic conflict;
  assign conflict = ($countones(io.req_valid) >= 2) && !flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_issue    <= '0;
      perf_conflict <= '0;
    end else if (perf_clr) begin
      perf_issue    <= '0;
      perf_conflict <= '0;
    end else begin
      if (gnt_any)  perf_issue    <= perf_issue + 32'd1;
      if (conflict) perf_conflict <= perf_conflict + 32'd1;
    end
  end
`endif
endmodule
